// File: rtl/mmu_pc.sv
// MMU control unit: sequences TLB hit/miss handling, page-table base load and TLB flush,
// and produces the beta strobes and alpha selectors for the MMU datapath registers.
module mmu_pc (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       rdyin,
    input  logic [1:0] op,
    input  logic       esito_ma,
    input  logic       ackinm,
    input  logic       esitom,
    input  logic       ackinc,
    input  logic       esitoc,
    output logic       bRdyin,
    output logic       bAckout,
    output logic       bEsito,
    output logic       bDataout,
    output logic       bIndoutc,
    output logic       bOpoutc,
    output logic       bDataoutc,
    output logic       bRdyoutc,
    output logic       bAckinc,
    output logic       bIndoutm,
    output logic       bOpoutm,
    output logic       bRdyoutm,
    output logic       bAckinm,
    output logic       bIndtabril,
    output logic       bReg_v,
    output logic       bFlush,
    output logic       bS,
    output logic       bCl,
    output logic       aKindoutc,
    output logic [1:0] aKesito,
    output logic       aKreg_v
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WAIT_M,
        WAIT_C
    } state_t;

    state_t state_q, state_d;

    // esitoc only reaches the datapath through the aKesito mux.
    logic unused_esitoc;
    assign unused_esitoc = esitoc;

    always_ff @(posedge clock) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        bRdyin     = 1'b0;
        bAckout    = 1'b0;
        bEsito     = 1'b0;
        bDataout   = 1'b0;
        bIndoutc   = 1'b0;
        bOpoutc    = 1'b0;
        bDataoutc  = 1'b0;
        bRdyoutc   = 1'b0;
        bAckinc    = 1'b0;
        bIndoutm   = 1'b0;
        bOpoutm    = 1'b0;
        bRdyoutm   = 1'b0;
        bAckinm    = 1'b0;
        bIndtabril = 1'b0;
        bReg_v     = 1'b0;
        bFlush     = 1'b0;
        bS         = 1'b0;
        bCl        = 1'b0;
        aKindoutc  = 1'b0;
        aKesito    = 2'b00;
        aKreg_v    = 1'b0;

        // Whole decode is suppressed while reset is held so no strobe escapes.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (!rdyin) begin
                        bAckinm = ackinm;
                        bAckinc = ackinc;
                    end else begin
                        bRdyin = 1'b1;
                        if (op == 2'b10) begin
                            bIndtabril = 1'b1;
                            aKesito    = 2'b00;
                            bEsito     = 1'b1;
                            bAckout    = 1'b1;
                        end else if (op == 2'b11) begin
                            bReg_v  = 1'b1;
                            aKreg_v = 1'b0;
                            state_d = FLUSH;
                        end else if (!esito_ma) begin
                            aKindoutc = 1'b0;
                            bIndoutc  = 1'b1;
                            bOpoutc   = 1'b1;
                            bDataoutc = 1'b1;
                            bRdyoutc  = 1'b1;
                            state_d   = WAIT_C;
                        end else begin
                            bIndoutm = 1'b1;
                            bOpoutm  = 1'b1;
                            bRdyoutm = 1'b1;
                            bReg_v   = 1'b1;
                            aKreg_v  = 1'b1;
                            state_d  = WAIT_M;
                        end
                    end
                end
                FLUSH: begin
                    bFlush  = 1'b1;
                    aKesito = 2'b00;
                    bEsito  = 1'b1;
                    bAckout = 1'b1;
                    state_d = IDLE;
                end
                WAIT_M: begin
                    if (ackinm) begin
                        bAckinm = 1'b1;
                        if (!esitom) begin
                            aKesito = 2'b10;
                            bEsito  = 1'b1;
                            bAckout = 1'b1;
                            state_d = IDLE;
                        end else begin
                            bS        = 1'b1;
                            bCl       = 1'b1;
                            aKindoutc = 1'b1;
                            bIndoutc  = 1'b1;
                            bOpoutc   = 1'b1;
                            bDataoutc = 1'b1;
                            bRdyoutc  = 1'b1;
                            state_d   = WAIT_C;
                        end
                    end
                end
                WAIT_C: begin
                    if (ackinc) begin
                        bAckinc  = 1'b1;
                        aKesito  = 2'b01;
                        bEsito   = 1'b1;
                        bDataout = 1'b1;
                        bAckout  = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_mmu_pc.sv
// Directed bench for mmu_pc: each cycle drives inputs and compares the full output vector
// against a hand-built expected value.
module tb_mmu_pc;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdyin = 1'b0;
    logic [1:0] op = 2'b00;
    logic       esito_ma = 1'b0;
    logic       ackinm = 1'b0;
    logic       esitom = 1'b0;
    logic       ackinc = 1'b0;
    logic       esitoc = 1'b0;
    logic bRdyin, bAckout, bEsito, bDataout;
    logic bIndoutc, bOpoutc, bDataoutc, bRdyoutc, bAckinc;
    logic bIndoutm, bOpoutm, bRdyoutm, bAckinm;
    logic bIndtabril, bReg_v, bFlush, bS, bCl;
    logic aKindoutc, aKreg_v;
    logic [1:0] aKesito;

    always #5 clock = ~clock;

    mmu_pc dut (
        .clock(clock), .rst_n(rst_n), .rdyin(rdyin), .op(op), .esito_ma(esito_ma),
        .ackinm(ackinm), .esitom(esitom), .ackinc(ackinc), .esitoc(esitoc),
        .bRdyin(bRdyin), .bAckout(bAckout), .bEsito(bEsito), .bDataout(bDataout),
        .bIndoutc(bIndoutc), .bOpoutc(bOpoutc), .bDataoutc(bDataoutc), .bRdyoutc(bRdyoutc),
        .bAckinc(bAckinc), .bIndoutm(bIndoutm), .bOpoutm(bOpoutm), .bRdyoutm(bRdyoutm),
        .bAckinm(bAckinm), .bIndtabril(bIndtabril), .bReg_v(bReg_v), .bFlush(bFlush),
        .bS(bS), .bCl(bCl), .aKindoutc(aKindoutc), .aKesito(aKesito), .aKreg_v(aKreg_v)
    );

    logic [21:0] outv;
    assign outv = {bRdyin, bAckout, bEsito, bDataout, bIndoutc, bOpoutc, bDataoutc,
                   bRdyoutc, bAckinc, bIndoutm, bOpoutm, bRdyoutm, bAckinm, bIndtabril,
                   bReg_v, bFlush, bS, bCl, aKindoutc, aKesito, aKreg_v};

    localparam logic [21:0] RDYIN  = 22'd1 << 21;
    localparam logic [21:0] ACKOUT = 22'd1 << 20;
    localparam logic [21:0] ESITO  = 22'd1 << 19;
    localparam logic [21:0] DOUT   = 22'd1 << 18;
    localparam logic [21:0] INDC   = 22'd1 << 17;
    localparam logic [21:0] OPC    = 22'd1 << 16;
    localparam logic [21:0] DATAC  = 22'd1 << 15;
    localparam logic [21:0] RDYC   = 22'd1 << 14;
    localparam logic [21:0] ACKINC = 22'd1 << 13;
    localparam logic [21:0] INDM   = 22'd1 << 12;
    localparam logic [21:0] OPM    = 22'd1 << 11;
    localparam logic [21:0] RDYM   = 22'd1 << 10;
    localparam logic [21:0] ACKINM = 22'd1 << 9;
    localparam logic [21:0] TABRIL = 22'd1 << 8;
    localparam logic [21:0] REGV   = 22'd1 << 7;
    localparam logic [21:0] FLUSHB = 22'd1 << 6;
    localparam logic [21:0] SB     = 22'd1 << 5;
    localparam logic [21:0] CLB    = 22'd1 << 4;
    localparam logic [21:0] KINDC  = 22'd1 << 3;
    localparam logic [21:0] KES_M  = 22'd1 << 2;
    localparam logic [21:0] KES_C  = 22'd1 << 1;
    localparam logic [21:0] KREGV  = 22'd1;

    localparam logic [21:0] NONE     = 22'd0;
    localparam logic [21:0] HIT_REQ  = RDYIN | INDC | OPC | DATAC | RDYC;
    localparam logic [21:0] MISS_REQ = RDYIN | INDM | OPM | RDYM | REGV | KREGV;
    localparam logic [21:0] BASE     = RDYIN | TABRIL | ESITO | ACKOUT;
    localparam logic [21:0] FL_REQ   = RDYIN | REGV;
    localparam logic [21:0] FL_DONE  = FLUSHB | ESITO | ACKOUT;
    localparam logic [21:0] FAULT    = ACKINM | KES_M | ESITO | ACKOUT;
    localparam logic [21:0] MEM_OK   = ACKINM | SB | CLB | KINDC | INDC | OPC | DATAC | RDYC;
    localparam logic [21:0] C_DONE   = ACKINC | KES_C | ESITO | DOUT | ACKOUT;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int cl_cnt = 0;
    int ack_cnt = 0;
    int req_cyc = 0;
    int ack_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs just after the edge, compare mid-cycle, then advance.
    task automatic cyc(input logic r, input logic [1:0] o, input logic ma, input logic am,
                       input logic em, input logic ac, input string tag,
                       input logic [21:0] exp);
        rdyin = r; op = o; esito_ma = ma; ackinm = am; esitom = em; ackinc = ac;
        esitoc = 1'b1;
        #2;
        check(tag, {10'd0, outv}, {10'd0, exp});
        if (bCl) begin
            cl_cnt++;
            check("cl_with_s", {31'd0, bS}, 32'd1);
        end
        if (bAckout) begin
            ack_cnt++;
            ack_cyc = cyc_n;
        end
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    initial begin
        @(posedge clock);
        #1;
        // Reset held with active inputs: everything must stay low.
        rst_n = 1'b0;
        cyc(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, "rst_quiet0", NONE);
        cyc(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, "rst_quiet1", NONE);
        rst_n = 1'b1;
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "idle", NONE);

        // Hit with 3-cycle cache wait.
        req_cyc = cyc_n;
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "hit_req", HIT_REQ);
        for (int unsigned i = 0; i < 3; i++)
            cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "hit_wait", NONE);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "hit_done", C_DONE);
        check("hit_lat", ack_cyc - req_cyc + 1, 5);

        // Miss then ok; a pending write request must be ignored until IDLE.
        req_cyc = cyc_n;
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, "miss_req", MISS_REQ);
        for (int unsigned i = 0; i < 2; i++)
            cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, "miss_waitm", NONE);
        cyc(1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, "miss_memok", MEM_OK);
        for (int unsigned i = 0; i < 2; i++)
            cyc(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, "miss_waitc", NONE);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, "miss_done", C_DONE);
        check("miss_lat", ack_cyc - req_cyc + 1, 7);
        // The pending request is served on return to IDLE (here: base load).
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "base", BASE);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "base_idle", NONE);

        // Page fault: no insertion, no cache betas.
        cl_cnt = 0;
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "pf_req", MISS_REQ);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, "pf_done", FAULT);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "pf_idle", NONE);
        check("pf_ncl", cl_cnt, 0);

        // Flush: two-cycle sequence, inputs in FLUSH are ignored.
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, "fl_req", FL_REQ);
        cyc(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, "fl_done", FL_DONE);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "fl_idle", NONE);

        // Stale replies drained in IDLE.
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, "drain_both", ACKINM | ACKINC);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "drain_c", ACKINC);

        // Nine consecutive successful misses.
        cl_cnt = 0;
        ack_cnt = 0;
        for (int unsigned i = 0; i < 9; i++) begin
            cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "m9_req", MISS_REQ);
            cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, "m9_memok", MEM_OK);
            cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "m9_done", C_DONE);
        end
        check("m9_ncl", cl_cnt, 9);
        check("m9_nack", ack_cnt, 9);

        // Reset in WAIT_M, then a late memory reply is only drained.
        cl_cnt = 0;
        ack_cnt = 0;
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "rm_req", MISS_REQ);
        rst_n = 1'b0;
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, "rm_rst", NONE);
        rst_n = 1'b1;
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, "rm_late", ACKINM);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "rm_idle", NONE);

        // Reset in WAIT_C, then a late cache reply is only drained.
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, "rc_req", HIT_REQ);
        rst_n = 1'b0;
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "rc_rst", NONE);
        rst_n = 1'b1;
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "rc_late", ACKINC);
        check("rst_nack", ack_cnt, 0);
        check("rst_ncl", cl_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
